// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
//   Shared definitions for the core fetch/execute sequencer:
//   - CTRL_W and the bit index of every datapath strobe carried in the packed ctrl word
//   - sequencer state encodings
//   - opcode class and memory sub-op constants of the mini ISA
//   - small helpers that build strobe masks and classify opcodes
//
//   Opcode layout: ir[7:6] = class, ir[3:0] = class payload, ir[5:4] unused.
//     MOV  00..ddss   ALU 01..oooo   MEM 10..ddkk (kk: 00 LDI, 01 LD, 10 ST, 11 NOP)
//     11..0000 = HLT, any other 11..xxxx = NOP
package core_ctrl_pkg;

   // Strobe bit map of the packed ctrl word
   localparam int A_ASSERT_MAIN      = 0;
   localparam int A_LOAD_MAIN        = 1;
   localparam int A_ASSERT_LHS       = 2;
   localparam int B_ASSERT_MAIN      = 3;
   localparam int B_LOAD_MAIN        = 4;
   localparam int B_ASSERT_RHS       = 5;
   localparam int C_ASSERT_MAIN      = 6;
   localparam int C_LOAD_MAIN        = 7;
   localparam int D_ASSERT_MAIN      = 8;
   localparam int D_LOAD_MAIN        = 9;
   localparam int CONST1_ASSERT_MAIN = 10;
   localparam int CONST1_LOAD_MEM    = 11;
   localparam int XFER_ASSERT_MAIN   = 12;
   localparam int XFER_LOAD_MAIN     = 13;
   localparam int PCRA0_ASSERT_ADDR  = 14;
   localparam int PCRA0_INC          = 15;
   localparam int PCRA1_ASSERT_ADDR  = 16;
   localparam int PCRA1_INC          = 17;
   localparam int SP_ASSERT_ADDR     = 18;
   localparam int SP_INC             = 19;
   localparam int SP_DEC             = 20;
   localparam int SI_ASSERT_ADDR     = 21;
   localparam int SI_INC             = 22;
   localparam int SI_DEC             = 23;
   localparam int DI_ASSERT_ADDR     = 24;
   localparam int DI_INC             = 25;
   localparam int DI_DEC             = 26;
   localparam int MEM_BUSDIR         = 27;   // 1 = memory drives the main bus
   localparam int MEM_ASSERT_MAIN    = 28;
   localparam int MEM_LOAD_MAIN      = 29;
   localparam int ALU_ASSERT_MAIN    = 30;
   localparam int ALU_OP_LSB         = 31;
   localparam int ALU_OP_W           = 4;
   localparam int CTRL_W             = ALU_OP_LSB + ALU_OP_W;

   typedef logic [CTRL_W-1:0] ctrl_t;

   // Sequencer states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_EXEC1 = 3'd2;
   localparam logic [2:0] ST_EXEC2 = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

   // Opcode classes (ir[7:6])
   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_ALU = 2'b01;
   localparam logic [1:0] OP_MEM = 2'b10;
   localparam logic [1:0] OP_HLT = 2'b11;

   // Memory-class sub-ops (ir[1:0])
   localparam logic [1:0] MEM_LDI = 2'b00;
   localparam logic [1:0] MEM_LD  = 2'b01;
   localparam logic [1:0] MEM_ST  = 2'b10;

   // Register select field encoding
   typedef enum logic [1:0] {
      REG_A = 2'b00,
      REG_B = 2'b01,
      REG_C = 2'b10,
      REG_D = 2'b11
   } reg_sel_e;

   function automatic ctrl_t bit_mask(input int idx);
      return ctrl_t'(1) << idx;
   endfunction

   // Strobe that puts the selected register onto the main bus
   function automatic ctrl_t reg_assert_mask(input logic [1:0] sel);
      ctrl_t m;
      case (reg_sel_e'(sel))
         REG_A:   m = bit_mask(A_ASSERT_MAIN);
         REG_B:   m = bit_mask(B_ASSERT_MAIN);
         REG_C:   m = bit_mask(C_ASSERT_MAIN);
         default: m = bit_mask(D_ASSERT_MAIN);
      endcase
      return m;
   endfunction

   // Strobe that loads the selected register from the main bus
   function automatic ctrl_t reg_load_mask(input logic [1:0] sel);
      ctrl_t m;
      case (reg_sel_e'(sel))
         REG_A:   m = bit_mask(A_LOAD_MAIN);
         REG_B:   m = bit_mask(B_LOAD_MAIN);
         REG_C:   m = bit_mask(C_LOAD_MAIN);
         default: m = bit_mask(D_LOAD_MAIN);
      endcase
      return m;
   endfunction

   // LDI is the only instruction that needs a second execute cycle
   function automatic logic is_ldi(input logic [1:0] cls, input logic [1:0] sub);
      return (cls == OP_MEM) && (sub == MEM_LDI);
   endfunction

   function automatic logic is_hlt(input logic [1:0] cls, input logic [3:0] payload);
      return (cls == OP_HLT) && (payload == 4'h0);
   endfunction

endpackage

// File: rtl/core_ctrl_decode.sv
// core_ctrl_decode
//   Purely combinational strobe decoder: maps (state, ir) onto the packed datapath
//   control word. Every strobe takes effect at the rising edge that ends the cycle.
//   Ports:
//     state  in   3       current sequencer state
//     ir     in   8       current instruction register
//     ctrl   out  CTRL_W  packed datapath strobes (bit map in core_ctrl_pkg)
//   Per cycle at most one main-bus and one addr-bus asserter is ever raised; the
//   xfer, pcra1, SP and SI/DI inc/dec strobes are never raised.
module core_ctrl_decode
   import core_ctrl_pkg::*;
(
   input  logic [2:0]        state,
   input  logic [7:0]        ir,
   output logic [CTRL_W-1:0] ctrl
);

   logic [1:0] cls;
   logic [1:0] dst;
   logic [1:0] src;
   logic       unused_ir_bits;

   assign cls = ir[7:6];
   assign dst = ir[3:2];   // dd for MOV/LDI/LD, rr for ST
   assign src = ir[1:0];   // ss for MOV, sub-op for the memory class

   // ir[5:4] carry no meaning in this ISA revision
   assign unused_ir_bits = ^ir[5:4];

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl = bit_mask(PCRA0_ASSERT_ADDR) | bit_mask(PCRA0_INC);
         end
         ST_EXEC1: begin
            case (cls)
               OP_MOV: begin
                  // Self-move would put one register on both ends of the bus; treat as NOP
                  if (dst != src) begin
                     ctrl = reg_assert_mask(src) | reg_load_mask(dst);
                  end
               end
               OP_ALU: begin
                  ctrl = bit_mask(A_ASSERT_LHS) | bit_mask(B_ASSERT_RHS)
                       | bit_mask(ALU_ASSERT_MAIN) | bit_mask(A_LOAD_MAIN)
                       | (ctrl_t'(ir[3:0]) << ALU_OP_LSB);
               end
               OP_MEM: begin
                  case (src)
                     MEM_LDI: begin
                        // Immediate byte follows the opcode; latch it into const1
                        ctrl = bit_mask(PCRA0_ASSERT_ADDR) | bit_mask(CONST1_LOAD_MEM)
                             | bit_mask(PCRA0_INC);
                     end
                     MEM_LD: begin
                        ctrl = bit_mask(SI_ASSERT_ADDR) | bit_mask(MEM_BUSDIR)
                             | bit_mask(MEM_ASSERT_MAIN) | reg_load_mask(dst);
                     end
                     MEM_ST: begin
                        // MEM_BUSDIR left low: main bus drives memory
                        ctrl = bit_mask(DI_ASSERT_ADDR) | reg_assert_mask(dst)
                             | bit_mask(MEM_LOAD_MAIN);
                     end
                     default: ctrl = '0;
                  endcase
               end
               default: ctrl = '0;   // HLT and the 11-class NOPs
            endcase
         end
         ST_EXEC2: begin
            if (is_ldi(cls, src)) begin
               ctrl = bit_mask(CONST1_ASSERT_MAIN) | reg_load_mask(dst);
            end
         end
         default: ctrl = '0;   // IDLE, HALT
      endcase
   end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
//   Fetch/execute controller for the core datapath. Fetches opcodes from memory at
//   PCRA0 into ir, then drives the datapath strobes one bus transfer per cycle.
//   Ports:
//     clk      in   1       rising-edge clock
//     reset    in   1       asynchronous, active-high; clears all state
//     run      in   1       1 = keep fetching; 0 = stop at next instruction boundary
//     mem_in   in   8       memory read data at the current address bus
//     ctrl     out  CTRL_W  packed datapath strobes (bit map in core_ctrl_pkg)
//     ir       out  8       current instruction register
//     busy     out  1       high in FETCH/EXEC1/EXEC2
//     halted   out  1       high in HALT
//     retired  out  CNT_W   completed-instruction count, saturating at all-ones
//   Instructions take FETCH + EXEC1 (2 cycles); LDI adds EXEC2 (3 cycles).
//   run is only looked at in IDLE and at the end of an instruction, so dropping it
//   never truncates an instruction. HALT is left only through reset.
module core_sequencer
   import core_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [7:0]        mem_in,
   output logic [CTRL_W-1:0] ctrl,
   output logic [7:0]        ir,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       ir_ldi;
   logic       ir_hlt;
   logic       instr_end;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign ir_ldi = is_ldi(ir[7:6], ir[1:0]);
   assign ir_hlt = is_hlt(ir[7:6], ir[3:0]);

   // LDI finishes in EXEC2; everything else (HLT included) finishes in EXEC1
   assign instr_end = ((state == ST_EXEC1) && !ir_ldi) || (state == ST_EXEC2);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = run ? ST_FETCH : ST_IDLE;
         ST_FETCH: state_nxt = ST_EXEC1;
         ST_EXEC1: begin
            if (ir_ldi) begin
               state_nxt = ST_EXEC2;
            end else if (ir_hlt) begin
               state_nxt = ST_HALT;
            end else begin
               state_nxt = run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_EXEC2: state_nxt = run ? ST_FETCH : ST_IDLE;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         ir      <= 8'h00;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH) begin
            ir <= mem_in;
         end
         if (instr_end) begin
            retired <= sat_inc(retired);
         end
      end
   end

   core_ctrl_decode u_decode (
      .state (state),
      .ir    (ir),
      .ctrl  (ctrl)
   );

   assign busy   = (state == ST_FETCH) || (state == ST_EXEC1) || (state == ST_EXEC2);
   assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
//   Drives core_sequencer with a small datapath/memory environment that obeys the
//   strobes, and compares against an instruction-level model of the mini ISA.
//   A second, narrow-counter instance exercises retired-count saturation.
module tb_core_sequencer;
   import core_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT
   logic        reset;
   logic        run;
   logic [7:0]  mem_in;
   ctrl_t       ctrl;
   logic [7:0]  ir;
   logic        busy;
   logic        halted;
   logic [15:0] retired;

   core_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_in(mem_in), .ctrl(ctrl),
      .ir(ir), .busy(busy), .halted(halted), .retired(retired)
   );

   // Saturation DUT: 4-bit counter fed a stream of 8'h00 NOPs
   logic        reset_s;
   logic        run_s;
   logic [7:0]  mem_in_s;
   ctrl_t       ctrl_s;
   logic [7:0]  ir_s;
   logic        busy_s;
   logic        halted_s;
   logic [3:0]  retired_s;

   core_sequencer #(.CNT_W(4)) dut_s (
      .clk(clk), .reset(reset_s), .run(run_s), .mem_in(mem_in_s), .ctrl(ctrl_s),
      .ir(ir_s), .busy(busy_s), .halted(halted_s), .retired(retired_s)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ALU operation table of the datapath
   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~a;
         default: return a;
      endcase
   endfunction

   // ---------------- datapath / memory environment ----------------
   logic [7:0] rf [4];
   logic [7:0] mem [256];
   logic [7:0] pc, si, di, const1;
   logic [7:0] main_bus, addr_bus;

   logic [7:0] prog [256];
   logic [7:0] rf_init [4];
   logic [7:0] si_init, di_init;
   logic       load_req = 1'b0;

   always_comb begin
      addr_bus = 8'h00;
      if (ctrl[PCRA0_ASSERT_ADDR]) addr_bus = pc;
      if (ctrl[SI_ASSERT_ADDR])    addr_bus = si;
      if (ctrl[DI_ASSERT_ADDR])    addr_bus = di;
      main_bus = 8'h00;
      if (ctrl[A_ASSERT_MAIN])      main_bus = rf[0];
      if (ctrl[B_ASSERT_MAIN])      main_bus = rf[1];
      if (ctrl[C_ASSERT_MAIN])      main_bus = rf[2];
      if (ctrl[D_ASSERT_MAIN])      main_bus = rf[3];
      if (ctrl[CONST1_ASSERT_MAIN]) main_bus = const1;
      if (ctrl[MEM_ASSERT_MAIN])    main_bus = mem[addr_bus];
      if (ctrl[ALU_ASSERT_MAIN])    main_bus = alu_f(rf[0], rf[1], ctrl[ALU_OP_LSB +: ALU_OP_W]);
   end

   assign mem_in = mem[addr_bus];

   always @(posedge clk) begin
      if (load_req) begin
         mem    <= prog;
         rf     <= rf_init;
         pc     <= 8'h00;
         si     <= si_init;
         di     <= di_init;
         const1 <= 8'h00;
      end else begin
         if (ctrl[A_LOAD_MAIN])     rf[0] <= main_bus;
         if (ctrl[B_LOAD_MAIN])     rf[1] <= main_bus;
         if (ctrl[C_LOAD_MAIN])     rf[2] <= main_bus;
         if (ctrl[D_LOAD_MAIN])     rf[3] <= main_bus;
         if (ctrl[CONST1_LOAD_MEM]) const1 <= mem[addr_bus];
         if (ctrl[MEM_LOAD_MAIN])   mem[addr_bus] <= main_bus;
         if (ctrl[PCRA0_INC])       pc <= pc + 8'h01;
      end
   end

   // ---------------- instruction-level reference model ----------------
   logic [7:0] m_rf [4];
   logic [7:0] m_mem [256];
   logic [7:0] m_pc;
   int         end_edge [64];   // edge (counted from run=1 in IDLE) at which instr j retires
   int         m_n;

   task automatic model_exec();
      int cum;
      logic [7:0] op;
      int len;
      m_mem = prog;
      m_rf  = rf_init;
      m_pc  = 8'h00;
      m_n   = 0;
      cum   = 0;
      for (int j = 0; j < 64; j++) begin
         op = m_mem[m_pc];
         m_pc = m_pc + 8'h01;
         len = 2;
         if (op[7:6] == 2'b00) begin
            m_rf[op[3:2]] = m_rf[op[1:0]];
         end else if (op[7:6] == 2'b01) begin
            m_rf[0] = alu_f(m_rf[0], m_rf[1], op[3:0]);
         end else if (op[7:6] == 2'b10) begin
            if (op[1:0] == 2'b00) begin
               m_rf[op[3:2]] = m_mem[m_pc];
               m_pc = m_pc + 8'h01;
               len = 3;
            end else if (op[1:0] == 2'b01) begin
               m_rf[op[3:2]] = m_mem[si_init];
            end else if (op[1:0] == 2'b10) begin
               m_mem[di_init] = m_rf[op[3:2]];
            end
         end
         cum = cum + len;
         end_edge[j] = 1 + cum;
         m_n = j + 1;
         if (op[7:6] == 2'b11 && op[3:0] == 4'h0) break;
      end
   endtask

   ctrl_t main_mask, addr_mask, tied_mask;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_invariants(input string tag, input ctrl_t c);
      chk({tag, "_main_asserters_le1"}, 64'($countones(c & main_mask) <= 1), 64'(1));
      chk({tag, "_addr_asserters_le1"}, 64'($countones(c & addr_mask) <= 1), 64'(1));
      chk({tag, "_tied_strobes"}, 64'(c & tied_mask), 64'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic load_env();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
   endtask

   logic [7:0] alu_seen;
   logic       alu_hit;

   // Runs the loaded program to HALT and compares cycle-by-cycle retirement and end state
   task automatic run_and_check(input string tag);
      int last;
      int exp_ret;
      int diffs;
      do_reset();
      load_env();
      model_exec();
      last = end_edge[m_n-1];
      alu_hit = 1'b0;
      alu_seen = 8'h00;
      run = 1'b1;
      for (int e = 1; e <= last; e++) begin
         step();
         if (ctrl[ALU_ASSERT_MAIN]) begin
            alu_hit = 1'b1;
            alu_seen = main_bus;
         end
         bus_invariants(tag, ctrl);
         exp_ret = 0;
         for (int j = 0; j < m_n; j++) if (end_edge[j] <= e) exp_ret++;
         chk($sformatf("%s_retired_e%0d", tag, e), 64'(retired), 64'(exp_ret));
         if (e == last - 1) chk({tag, "_not_yet_halted"}, 64'(halted), 64'(0));
      end
      run = 1'b0;
      chk({tag, "_halted"}, 64'(halted), 64'(1));
      chk({tag, "_busy_in_halt"}, 64'(busy), 64'(0));
      chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
      for (int r = 0; r < 4; r++) chk($sformatf("%s_reg%0d", tag, r), 64'(rf[r]), 64'(m_rf[r]));
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
      chk({tag, "_mem_diffs"}, 64'(diffs), 64'(0));
      // HALT ignores run and keeps strobes quiet
      run = 1'b1;
      step();
      step();
      run = 1'b0;
      chk({tag, "_halt_sticky"}, 64'(halted), 64'(1));
      chk({tag, "_halt_ctrl"}, 64'(ctrl), 64'(0));
      chk({tag, "_halt_retired"}, 64'(retired), 64'(m_n));
   endtask

   task automatic clear_env();
      for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
      for (int r = 0; r < 4; r++) rf_init[r] = 8'($urandom);
      si_init = 8'h80 | 8'($urandom_range(0, 63));
      di_init = 8'hC0 | 8'($urandom_range(0, 63));
   endtask

   initial begin
      main_mask = bit_mask(A_ASSERT_MAIN) | bit_mask(B_ASSERT_MAIN) | bit_mask(C_ASSERT_MAIN)
                | bit_mask(D_ASSERT_MAIN) | bit_mask(CONST1_ASSERT_MAIN) | bit_mask(XFER_ASSERT_MAIN)
                | bit_mask(MEM_ASSERT_MAIN) | bit_mask(ALU_ASSERT_MAIN);
      addr_mask = bit_mask(PCRA0_ASSERT_ADDR) | bit_mask(PCRA1_ASSERT_ADDR) | bit_mask(SP_ASSERT_ADDR)
                | bit_mask(SI_ASSERT_ADDR) | bit_mask(DI_ASSERT_ADDR);
      tied_mask = bit_mask(XFER_ASSERT_MAIN) | bit_mask(XFER_LOAD_MAIN) | bit_mask(PCRA1_ASSERT_ADDR)
                | bit_mask(PCRA1_INC) | bit_mask(SP_ASSERT_ADDR) | bit_mask(SP_INC) | bit_mask(SP_DEC)
                | bit_mask(SI_INC) | bit_mask(SI_DEC) | bit_mask(DI_INC) | bit_mask(DI_DEC);

      reset = 1'b1;
      run = 1'b0;
      reset_s = 1'b1;
      run_s = 1'b0;
      mem_in_s = 8'h00;
      clear_env();
      #1;

      // Reset state (async, before any clock edge)
      chk("rst_ctrl", 64'(ctrl), 64'(0));
      chk("rst_ir", 64'(ir), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_halted", 64'(halted), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      step();
      reset = 1'b0;
      step();
      chk("idle_ctrl", 64'(ctrl), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));

      // LDI A,5A ; HLT
      clear_env();
      prog[0] = 8'h80; prog[1] = 8'h5A; prog[2] = 8'hC0;
      run_and_check("ldi_hlt");
      chk("ldi_hlt_A", 64'(rf[0]), 64'(8'h5A));
      chk("ldi_hlt_retired", 64'(retired), 64'(2));
      chk("ldi_hlt_pc", 64'(pc), 64'(3));
      chk("ldi_hlt_ir", 64'(ir), 64'(8'hC0));

      // LDI B,03 ; LDI A,04 ; ADD ; HLT
      clear_env();
      prog[0] = 8'h84; prog[1] = 8'h03; prog[2] = 8'h80; prog[3] = 8'h04;
      prog[4] = 8'h40; prog[5] = 8'hC0;
      run_and_check("alu_add");
      chk("alu_add_bus_seen", 64'(alu_hit), 64'(1));
      chk("alu_add_bus", 64'(alu_seen), 64'(8'h07));
      chk("alu_add_A", 64'(rf[0]), 64'(8'h07));
      chk("alu_add_retired", 64'(retired), 64'(4));

      // LD C,[SI] ; ST [DI],D ; HLT
      clear_env();
      prog[0] = 8'h89; prog[1] = 8'h8E; prog[2] = 8'hC0;
      si_init = 8'h10; di_init = 8'h20;
      prog[8'h10] = 8'hA5;
      rf_init[3] = 8'h3C;
      run_and_check("ld_st");
      chk("ld_st_C", 64'(rf[2]), 64'(8'hA5));
      chk("ld_st_mem20", 64'(mem[8'h20]), 64'(8'h3C));

      // run pulsed for one cycle: exactly one instruction (MOV C,D) completes
      clear_env();
      prog[0] = 8'h1B;
      do_reset();
      load_env();
      run = 1'b1;
      step();
      run = 1'b0;
      chk("pulse_fetch_busy", 64'(busy), 64'(1));
      step();
      step();
      chk("pulse_idle_busy", 64'(busy), 64'(0));
      chk("pulse_idle_halted", 64'(halted), 64'(0));
      chk("pulse_idle_ctrl", 64'(ctrl), 64'(0));
      chk("pulse_retired", 64'(retired), 64'(1));
      step();
      step();
      step();
      chk("pulse_stays_idle", 64'(busy), 64'(0));
      chk("pulse_retired_hold", 64'(retired), 64'(1));
      chk("pulse_pc", 64'(pc), 64'(1));
      chk("pulse_C_eq_D", 64'(rf[2]), 64'(rf_init[3]));

      // Reset during EXEC2 of LDI C,77
      clear_env();
      prog[0] = 8'h88; prog[1] = 8'h77; prog[2] = 8'h5C;
      rf_init[2] = 8'h11;
      do_reset();
      load_env();
      run = 1'b1;
      step();
      step();
      step();
      chk("exec2_c_load", 64'(ctrl[C_LOAD_MAIN]), 64'(1));
      reset = 1'b1;
      run = 1'b0;
      #1;
      chk("async_rst_ctrl", 64'(ctrl), 64'(0));
      chk("async_rst_busy", 64'(busy), 64'(0));
      chk("async_rst_ir", 64'(ir), 64'(0));
      chk("async_rst_retired", 64'(retired), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_dest_unchanged", 64'(rf[2]), 64'(8'h11));
      chk("rst_pc_kept", 64'(pc), 64'(2));
      run = 1'b1;
      step();
      run = 1'b0;
      chk("refetch_busy", 64'(busy), 64'(1));
      chk("refetch_addr", 64'(ctrl[PCRA0_ASSERT_ADDR]), 64'(1));
      chk("refetch_data", 64'(mem_in), 64'(8'h5C));

      // Random opcode streams ending in HLT
      for (int p = 0; p < 6; p++) begin
         int pos;
         logic [7:0] op;
         clear_env();
         pos = 0;
         for (int i = 0; i < 24; i++) begin
            op = 8'($urandom);
            if (op[7:6] == 2'b11 && op[3:0] == 4'h0) op[0] = 1'b1;
            prog[pos] = op;
            pos++;
            if (op[7:6] == 2'b10 && op[1:0] == 2'b00) begin
               prog[pos] = 8'($urandom);
               pos++;
            end
         end
         prog[pos] = 8'hC0 | {2'b00, 2'($urandom), 4'h0};
         run_and_check($sformatf("rand%0d", p));
      end

      // Saturation of a 4-bit retired counter on a NOP stream
      reset_s = 1'b0;
      run_s = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         int exp_s;
         step();
         exp_s = (e - 1) / 2;
         if (exp_s > 15) exp_s = 15;
         chk($sformatf("sat_retired_e%0d", e), 64'(retired_s), 64'(exp_s));
      end
      chk("sat_not_halted", 64'(halted_s), 64'(0));
      chk("sat_busy", 64'(busy_s), 64'(1));
      run_s = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
